// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and data-memory wait/timeout freeze.
// The outputs are combinational from the state and the inputs. The state, the wait counter, the error flag and the stall counter are registered.
module pipe_ctrl #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             idex_memread,
   input  logic [4:0]       idex_rt,
   input  logic [4:0]       ifid_rs,
   input  logic [4:0]       ifid_rt,
   input  logic             ifid_uses_rt,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_we,
   output logic             memwb_valid,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [1:0] RUN      = 2'd0;
   localparam logic [1:0] MEM_WAIT = 2'd1;
   localparam logic [1:0] HALT     = 2'd2;

   localparam logic [7:0] TIMEOUT_L = TIMEOUT[7:0];

   logic [1:0]       state_q, state_d;
   logic [7:0]       wait_q, wait_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             freeze;
   logic             load_use;

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      err_d   = err_q;
      freeze  = 1'b0;
      case (state_q)
         RUN: begin
            if (mem_req && !mem_ready) begin
               freeze  = 1'b1;
               state_d = MEM_WAIT;
               wait_d  = 8'd1;
            end
         end
         MEM_WAIT: begin
            if (mem_ready) begin
               state_d = RUN;
               wait_d  = '0;
            end else if (wait_q < TIMEOUT_L) begin
               freeze = 1'b1;
               wait_d = wait_q + 8'd1;
            end else begin
               freeze  = 1'b1;
               state_d = HALT;
               err_d   = 1'b1;
            end
         end
         HALT: freeze = 1'b1;
         default: begin
            freeze  = 1'b1;
            state_d = RUN;
         end
      endcase
   end

   assign load_use = idex_memread && (idex_rt != 5'd0) &&
                     ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

   // Priority chain: reset, then the memory freeze, then the branch flush, then the load-use stall.
   always_comb begin
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_we    = 1'b1;
      memwb_valid = 1'b1;
      if (!rst_n) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_we    = 1'b0;
         memwb_valid = 1'b0;
      end else if (freeze) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         exmem_we    = 1'b0;
         memwb_valid = 1'b0;
      end else if (branch_taken) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (load_use) begin
         pc_we      = 1'b0;
         ifid_we    = 1'b0;
         idex_flush = 1'b1;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (!pc_we && (cnt_q != '1))
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         wait_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign mem_err   = err_q;
   assign stall_cnt = cnt_q;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, max consecutive MEM_WAIT cycles before halt (range 1..255).
REQ-002 Parameter CNT_W, default 16, width of stall_cnt.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 idex_memread  in  1  instruction in EX is a load.
REQ-006 idex_rt  in  5  load destination register in EX.
REQ-007 ifid_rs  in  5  rs of instruction in ID.
REQ-008 ifid_rt  in  5  rt of instruction in ID.
REQ-009 ifid_uses_rt  in  1  ID instruction reads rt.
REQ-010 branch_taken  in  1  branch/jump resolved taken in EX this cycle.
REQ-011 mem_req  in  1  MEM stage issues a data-memory access.
REQ-012 mem_ready  in  1  data memory completes the access this cycle.
REQ-013 pc_we  out  1  PC load enable.
REQ-014 ifid_we  out  1  IF/ID register load enable.
REQ-015 ifid_flush  out  1  IF/ID load a bubble.
REQ-016 idex_flush  out  1  ID/EX load a bubble (control bits zero).
REQ-017 exmem_we  out  1  EX/MEM register load enable.
REQ-018 memwb_valid  out  1  MEM/WB captures a valid instruction; 0 forces Regwrite and MemtoReg to 0 at MEM/WB input.
REQ-019 mem_err  out  1  sticky memory-timeout flag.
REQ-020 stall_cnt  out  CNT_W  saturating count of cycles with pc_we=0.

Function
REQ-021 FSM SHALL have states RUN, MEM_WAIT, HALT; outputs combinational from state and inputs, counters/state registered.
REQ-022 Freeze SHALL mean pc_we=ifid_we=exmem_we=0, memwb_valid=0, ifid_flush=idex_flush=0.
REQ-023 Normal SHALL mean pc_we=ifid_we=exmem_we=memwb_valid=1, flushes 0, then modified by REQ-024..026.
REQ-024 Load-use: idex_memread=1, idex_rt!=0, and (idex_rt==ifid_rs or (ifid_uses_rt and idex_rt==ifid_rt)) SHALL give pc_we=0, ifid_we=0, idex_flush=1.
REQ-025 branch_taken=1 SHALL give ifid_flush=1, idex_flush=1, pc_we=1, ifid_we=1, overriding load-use in the same cycle.
REQ-026 Priority SHALL be memory freeze > branch flush > load-use stall.
REQ-027 RUN: mem_req=1 and mem_ready=0 -> freeze, next state MEM_WAIT, wait_cnt<=1; otherwise normal, stay RUN.
REQ-028 MEM_WAIT: mem_ready=1 -> normal (hazards evaluated), next RUN, wait_cnt<=0.
REQ-029 MEM_WAIT: mem_ready=0 and wait_cnt<TIMEOUT -> freeze, wait_cnt increments.
REQ-030 MEM_WAIT: mem_ready=0 and wait_cnt==TIMEOUT -> freeze, next HALT, mem_err<=1.
REQ-031 HALT: freeze every cycle; exit only via reset; mem_ready ignored.
REQ-032 mem_ready=1 arriving in the same cycle as mem_req in RUN SHALL cause no wait (zero-stall access).
REQ-033 stall_cnt SHALL increment on every clock edge where pc_we=0 and rst_n=1, saturating at all-ones (no wrap).
REQ-034 mem_err SHALL stay 1 until reset.

Reset
REQ-035 rst_n=0 SHALL immediately (asynchronously) force state=RUN, wait_cnt=0, stall_cnt=0, mem_err=0.
REQ-036 While rst_n=0, pc_we=ifid_we=exmem_we=memwb_valid=0 and ifid_flush=idex_flush=1.
REQ-037 Reset asserted mid-MEM_WAIT or in HALT SHALL abandon the access; first cycle after release is RUN with normal outputs.

Verification
REQ-038 Load-use: idex_memread=1, idex_rt=5, ifid_rs=5 -> pc_we=0, ifid_we=0, idex_flush=1, stall_cnt +1; ifid_rs=0 with idex_rt=0 -> no stall.
REQ-039 Branch + load-use same cycle: branch_taken=1 with REQ-024 match -> ifid_flush=1, idex_flush=1, pc_we=1, stall_cnt unchanged.
REQ-040 Memory wait: mem_req=1, mem_ready low 3 cycles then high -> 3 freeze cycles (memwb_valid=0), 4th cycle normal, stall_cnt=3, state RUN.
REQ-041 Timeout: TIMEOUT=4, mem_ready never asserted -> freeze cycles 1..5, mem_err=1 after 5th edge, HALT persists 20 further cycles with freeze despite mem_ready=1.
REQ-042 Reset in HALT: rst_n pulsed low -> mem_err=0, stall_cnt=0, outputs normal next cycle.
REQ-043 Saturation: CNT_W=4, 20 consecutive stall cycles -> stall_cnt=15 and holds.
